// File: rtl/refund_dispenser.sv
// refund_dispenser: greedy 10/5/1 coin payout over a valid/ack hopper handshake; REFUND_TIMEOUT_EN adds an ack timeout with sticky fault.
module refund_dispenser #(
  parameter int AMT_W = 6,
  parameter int PULSE_GAP = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AMT_W-1:0] refund_in,
  input  logic             refund_valid,
  output logic [AMT_W-1:0] coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic [AMT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             fault
);
  localparam int CW = 8;
  typedef enum logic [2:0] {IDLE, SELECT, OFFER, GAP, DONE} state_t;
  state_t state, state_n;
  logic [AMT_W-1:0] coin_out_n, remaining_n;
  logic coin_valid_n, busy_n, fault_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      coin_out <= '0;
      coin_valid <= 1'b0;
      remaining <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      coin_out <= coin_out_n;
      coin_valid <= coin_valid_n;
      remaining <= remaining_n;
      busy <= busy_n;
      done <= state_n == DONE;
      fault <= fault_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    coin_out_n = coin_out;
    coin_valid_n = coin_valid;
    remaining_n = remaining;
    busy_n = busy;
    fault_n = fault;
    cnt_n = cnt;
    case (state)
      IDLE: if (refund_valid) begin
        remaining_n = refund_in;
        busy_n = 1'b1;
        fault_n = 1'b0;
        state_n = SELECT;
      end
      SELECT: begin
        cnt_n = '0;
        if (remaining == '0) state_n = DONE;
        else begin
          coin_out_n = remaining >= AMT_W'(10) ? AMT_W'(10) :
                       remaining >= AMT_W'(5)  ? AMT_W'(5)  : AMT_W'(1);
          coin_valid_n = 1'b1;
          state_n = OFFER;
        end
      end
      OFFER: if (coin_ack) begin
        remaining_n = remaining - coin_out;
        coin_valid_n = 1'b0;
        coin_out_n = '0;
        cnt_n = '0;
        state_n = PULSE_GAP > 0 ? GAP : SELECT;
      end
`ifdef REFUND_TIMEOUT_EN
      // the unacknowledged coin stays counted in remaining
      else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
        coin_valid_n = 1'b0;
        coin_out_n = '0;
        fault_n = 1'b1;
        state_n = DONE;
      end else cnt_n = cnt + 1'b1;
`endif
      GAP: if (cnt == CW'(PULSE_GAP - 1)) state_n = SELECT;
           else cnt_n = cnt + 1'b1;
      DONE: begin
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
